// File: rtl/vga_flash_responder.sv
// vga_flash_responder: serves VGA framebuffer-fill word reads from a 16-bit
// asynchronous NOR flash. Runs the flash power-up sequence, then performs one
// timed read per request and returns the word with a multi-cycle success pulse.
module vga_flash_responder #(
  parameter int RP_CYCLES      = 4,
  parameter int RECOVER_CYCLES = 8,
  parameter int READ_CYCLES    = 6,
  parameter int SUCCESS_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_re,
  input  logic [22:0] vga_addr,
  output logic [15:0] vga_data,
  output logic        vga_success,
  output logic        ready,
  output logic [22:0] flash_a,
  inout  wire  [15:0] flash_d,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n,
  output logic        flash_rp_n,
  output logic        flash_byte_n,
  output logic        flash_vpen
);

  typedef enum logic [2:0] {
    PWRUP,
    RECOVER,
    IDLE,
    ACCESS,
    RESP,
    GAP
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        latch_addr;
  logic        capture_data;

  // The flash is read-only from this block: data bus released, writes and
  // programming disabled, word mode selected.
  assign flash_d      = 16'hzzzz;
  assign flash_we_n   = 1'b1;
  assign flash_byte_n = 1'b1;
  assign flash_vpen   = 1'b0;

  // Status and strobes decode straight from the state register so they are
  // glitch-free and take their reset values on the reset edge.
  assign flash_rp_n  = (state != PWRUP);
  assign ready       = (state == IDLE) || (state == ACCESS) ||
                       (state == RESP) || (state == GAP);
  assign flash_ce_n  = (state != ACCESS);
  assign flash_oe_n  = (state != ACCESS);
  assign vga_success = (state == RESP);

  // State and phase counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PWRUP;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic: each timed phase counts 0..N-1 and restarts the counter
  // on exit.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt + 8'd1;
    latch_addr   = 1'b0;
    capture_data = 1'b0;
    case (state)
      PWRUP: begin
        if (cnt == 8'(RP_CYCLES - 1)) begin
          state_nx = RECOVER;
          cnt_nx   = 8'd0;
        end
      end
      RECOVER: begin
        if (cnt == 8'(RECOVER_CYCLES - 1)) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end
      end
      IDLE: begin
        cnt_nx = 8'd0;
        if (vga_re) begin
          latch_addr = 1'b1;
          state_nx   = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 8'(READ_CYCLES - 1)) begin
          capture_data = 1'b1;
          state_nx     = RESP;
          cnt_nx       = 8'd0;
        end
      end
      RESP: begin
        if (cnt == 8'(SUCCESS_CYCLES - 1)) begin
          state_nx = GAP;
          cnt_nx   = 8'd0;
        end
      end
      GAP: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
      default: begin
        state_nx = PWRUP;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // Address latch and read-data capture; both hold between accesses so the
  // address stays stable through ACCESS and the word stays frozen through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_a  <= 23'd0;
      vga_data <= 16'd0;
    end else begin
      if (latch_addr) begin
        flash_a <= vga_addr & ~23'd1;
      end
      if (capture_data) begin
        vga_data <= flash_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_flash_responder.sv
// Directed testbench for vga_flash_responder with a small asynchronous flash
// model that drives the data bus while ce_n and oe_n are both low.
module tb_vga_flash_responder;

  logic        clk;
  logic        rst;
  logic        vga_re;
  logic [22:0] vga_addr;
  logic [15:0] vga_data;
  logic        vga_success;
  logic        ready;
  logic [22:0] flash_a;
  wire  [15:0] flash_d;
  logic        flash_ce_n;
  logic        flash_oe_n;
  logic        flash_we_n;
  logic        flash_rp_n;
  logic        flash_byte_n;
  logic        flash_vpen;

  logic [15:0] mem [0:31];

  int n_checks;
  int n_pass;

  // observation results filled by observe()
  int          ce_low, oe_low, first_succ, succ_cnt;
  logic [22:0] a0;
  logic [15:0] d0;
  logic        addr_changed, data_changed, succ_after, fin_ce;
  logic [15:0] fin_data;

  vga_flash_responder dut (
    .clk          (clk),
    .rst          (rst),
    .vga_re       (vga_re),
    .vga_addr     (vga_addr),
    .vga_data     (vga_data),
    .vga_success  (vga_success),
    .ready        (ready),
    .flash_a      (flash_a),
    .flash_d      (flash_d),
    .flash_ce_n   (flash_ce_n),
    .flash_oe_n   (flash_oe_n),
    .flash_we_n   (flash_we_n),
    .flash_rp_n   (flash_rp_n),
    .flash_byte_n (flash_byte_n),
    .flash_vpen   (flash_vpen)
  );

  assign flash_d = (!flash_ce_n && !flash_oe_n) ? mem[flash_a[5:1]] : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request is presented at the current negedge; watch ncyc following cycles.
  task automatic observe(input int ncyc, input int drop_k);
    ce_low = 0; oe_low = 0; first_succ = -1; succ_cnt = 0;
    a0 = '0; d0 = '0; addr_changed = 0; data_changed = 0; succ_after = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (!flash_ce_n) begin
        if (ce_low == 0) a0 = flash_a;
        else if (flash_a !== a0) addr_changed = 1;
        ce_low++;
      end
      if (!flash_oe_n) oe_low++;
      if (vga_success) begin
        if (first_succ < 0) begin
          first_succ = k;
          d0 = vga_data;
        end else if (vga_data !== d0) data_changed = 1;
        succ_cnt++;
      end
      if (first_succ >= 0 && k == first_succ + 3) succ_after = vga_success;
      if (k == drop_k) vga_re = 1'b0;
    end
    fin_ce   = flash_ce_n;
    fin_data = vga_data;
  endtask

  task automatic test_reset();
    int rp_low, ready_low;
    logic seen_ready, ce_early;
    @(negedge clk);
    rst = 1'b1; vga_re = 1'b1; vga_addr = 23'd0;
    @(negedge clk);
    n_checks++; if (vga_success !== 1'b0) $display("FAIL rst_success got %b want 0", vga_success); else n_pass++;
    n_checks++; if (vga_data !== 16'h0) $display("FAIL rst_data got %h want 0000", vga_data); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL rst_ready got %b want 0", ready); else n_pass++;
    n_checks++; if (flash_a !== 23'd0) $display("FAIL rst_flash_a got %h want 0", flash_a); else n_pass++;
    n_checks++; if (flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1) $display("FAIL rst_ce_oe got %b%b want 11", flash_ce_n, flash_oe_n); else n_pass++;
    n_checks++; if (flash_rp_n !== 1'b0) $display("FAIL rst_rp_n got %b want 0", flash_rp_n); else n_pass++;
    n_checks++;
    if ({flash_we_n, flash_byte_n, flash_vpen} !== 3'b110)
      $display("FAIL rst_const_pins got %b want 110", {flash_we_n, flash_byte_n, flash_vpen});
    else n_pass++;
    rst = 1'b0;
    rp_low = 0; ready_low = 0; seen_ready = 0; ce_early = 0;
    for (int i = 0; i < 20; i++) begin
      if (!flash_rp_n) rp_low++;
      if (ready) seen_ready = 1;
      else if (!seen_ready) ready_low++;
      if (!ready && !flash_ce_n) ce_early = 1;
      @(negedge clk);
    end
    vga_re = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (rp_low !== 4) $display("FAIL pwrup_rp_low got %0d want 4", rp_low); else n_pass++;
    n_checks++; if (ready_low !== 12) $display("FAIL pwrup_ready_low got %0d want 12", ready_low); else n_pass++;
    n_checks++; if (ce_early !== 1'b0) $display("FAIL pwrup_ce_before_ready got %b want 0", ce_early); else n_pass++;
    n_checks++; if (vga_data !== 16'h1111) $display("FAIL pwrup_pending_read got %h want 1111", vga_data); else n_pass++;
  endtask

  task automatic test_single();
    vga_addr = 23'h000010; vga_re = 1'b1;
    observe(16, 1);
    n_checks++; if (a0 !== 23'h000010) $display("FAIL single_flash_a got %h want 000010", a0); else n_pass++;
    n_checks++; if (addr_changed !== 1'b0) $display("FAIL single_addr_stable got %b want 0", addr_changed); else n_pass++;
    n_checks++; if (ce_low !== 6) $display("FAIL single_ce_low got %0d want 6", ce_low); else n_pass++;
    n_checks++; if (oe_low !== 6) $display("FAIL single_oe_low got %0d want 6", oe_low); else n_pass++;
    n_checks++; if (first_succ !== 7) $display("FAIL single_latency got %0d want 7", first_succ); else n_pass++;
    n_checks++; if (succ_cnt !== 3) $display("FAIL single_success_len got %0d want 3", succ_cnt); else n_pass++;
    n_checks++; if (d0 !== 16'hA55A) $display("FAIL single_data got %h want a55a", d0); else n_pass++;
    n_checks++; if (data_changed !== 1'b0) $display("FAIL single_data_frozen got %b want 0", data_changed); else n_pass++;
    n_checks++; if (succ_after !== 1'b0) $display("FAIL single_gap got %b want 0", succ_after); else n_pass++;
    n_checks++; if (fin_ce !== 1'b1) $display("FAIL single_idle_ce got %b want 1", fin_ce); else n_pass++;
    n_checks++; if (fin_data !== 16'hA55A) $display("FAIL single_data_hold got %h want a55a", fin_data); else n_pass++;
  endtask

  task automatic test_odd_addr();
    vga_addr = 23'h000003; vga_re = 1'b1;
    observe(16, 1);
    n_checks++; if (a0 !== 23'h000002) $display("FAIL odd_flash_a got %h want 000002", a0); else n_pass++;
    n_checks++; if (d0 !== 16'h2222) $display("FAIL odd_data got %h want 2222", d0); else n_pass++;
    n_checks++; if (succ_cnt !== 3) $display("FAIL odd_success_len got %0d want 3", succ_cnt); else n_pass++;
  endtask

  task automatic test_drop_re();
    vga_addr = 23'h000004; vga_re = 1'b1;
    observe(20, 3);
    n_checks++; if (succ_cnt !== 3) $display("FAIL drop_success_len got %0d want 3", succ_cnt); else n_pass++;
    n_checks++; if (ce_low !== 6) $display("FAIL drop_ce_low got %0d want 6", ce_low); else n_pass++;
    n_checks++; if (d0 !== 16'h3333) $display("FAIL drop_data got %h want 3333", d0); else n_pass++;
    n_checks++; if (fin_ce !== 1'b1) $display("FAIL drop_idle_ce got %b want 1", fin_ce); else n_pass++;
  endtask

  task automatic test_stream();
    logic [22:0] got_a [0:7];
    logic [15:0] got_d [0:3];
    int          rise_k [0:3];
    logic [15:0] exp_d [0:3];
    logic [22:0] resp_a;
    logic        prev_s, prev_ce, resp_moved, bad_run;
    int          na, w, run;
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
    for (int i = 0; i < 8; i++) got_a[i] = '0;
    for (int i = 0; i < 4; i++) begin got_d[i] = '0; rise_k[i] = 0; end
    prev_s = 0; prev_ce = 1; resp_moved = 0; bad_run = 0; resp_a = '0;
    na = 0; w = 0; run = 0;
    vga_addr = 23'd0; vga_re = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (!flash_ce_n && prev_ce) begin
        if (na < 8) got_a[na] = flash_a;
        na++;
      end
      if (vga_success && !prev_s) begin
        if (w < 4) begin got_d[w] = vga_data; rise_k[w] = k; end
        w++;
        resp_a = flash_a;
        vga_addr = vga_addr + 23'd2;
        if (w == 4) vga_re = 1'b0;
      end else if (vga_success && flash_a !== resp_a) resp_moved = 1;
      if (vga_success) run++;
      else if (prev_s) begin
        if (run != 3) bad_run = 1;
        run = 0;
      end
      prev_s = vga_success;
      prev_ce = flash_ce_n;
    end
    n_checks++; if (na !== 4) $display("FAIL stream_accesses got %0d want 4", na); else n_pass++;
    n_checks++; if (w !== 4) $display("FAIL stream_responses got %0d want 4", w); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_a[i] !== 23'(2 * i)) $display("FAIL stream_addr[%0d] got %h want %h", i, got_a[i], 23'(2 * i));
      else n_pass++;
      n_checks++;
      if (got_d[i] !== exp_d[i]) $display("FAIL stream_data[%0d] got %h want %h", i, got_d[i], exp_d[i]);
      else n_pass++;
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (rise_k[i] - rise_k[i-1] !== 11)
        $display("FAIL stream_period[%0d] got %0d want 11", i, rise_k[i] - rise_k[i-1]);
      else n_pass++;
    end
    n_checks++; if (bad_run !== 1'b0) $display("FAIL stream_success_runs got %b want 0", bad_run); else n_pass++;
    n_checks++; if (resp_moved !== 1'b0) $display("FAIL stream_addr_ignored_in_resp got %b want 0", resp_moved); else n_pass++;
  endtask

  task automatic test_rst_mid();
    vga_addr = 23'h000010; vga_re = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) vga_re = 1'b0;
    end
    n_checks++; if (vga_success !== 1'b1) $display("FAIL mid_resp_active got %b want 1", vga_success); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (vga_success !== 1'b0) $display("FAIL mid_rst_success got %b want 0", vga_success); else n_pass++;
    n_checks++; if (flash_rp_n !== 1'b0) $display("FAIL mid_rst_rp_n got %b want 0", flash_rp_n); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL mid_rst_ready got %b want 0", ready); else n_pass++;
    n_checks++; if (flash_ce_n !== 1'b1) $display("FAIL mid_rst_ce_n got %b want 1", flash_ce_n); else n_pass++;
    n_checks++; if (vga_data !== 16'h0) $display("FAIL mid_rst_data got %h want 0000", vga_data); else n_pass++;
    repeat (11) @(negedge clk);
    n_checks++; if (ready !== 1'b0) $display("FAIL mid_ready_early got %b want 0", ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) $display("FAIL mid_ready_restored got %b want 1", ready); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    vga_re   = 1'b0;
    vga_addr = 23'd0;
    for (int i = 0; i < 32; i++) mem[i] = 16'hF000 | 16'(i);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;
    mem[8] = 16'hA55A;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_odd_addr();
    test_drop_re();
    test_stream();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
